// File: rtl/ctr_block_scheduler.sv
// CTR-mode block scheduler: drives one AES-256 core over up to NBLK counter blocks
// and XORs the returned keystream into the latched plaintext.
module ctr_block_scheduler #(
    parameter int NBLK  = 8,
    parameter int BLK_W = 128,
    parameter int KEY_W = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            num_blocks,
    input  logic [NBLK*BLK_W-1:0] plaintext_in,
    input  logic [KEY_W-1:0]      key,
    input  logic [BLK_W-1:0]      iv,
    output logic                  busy,
    output logic                  done,
    output logic [NBLK*BLK_W-1:0] text,
    output logic                  aes_start,
    output logic [KEY_W-1:0]      aes_key,
    output logic [BLK_W-1:0]      aes_in,
    input  logic                  aes_done,
    input  logic [BLK_W-1:0]      aes_out
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] NBLK_MAX = 4'(NBLK);

    state_t                  state;
    state_t                  state_next;
    logic [NBLK*BLK_W-1:0]   pt_q;
    logic [BLK_W-1:0]        iv_q;
    logic [3:0]              n_q;
    logic [3:0]              idx;
    logic [3:0]              n_req;
    logic                    last_blk;

    assign n_req    = (num_blocks > NBLK_MAX) ? NBLK_MAX : num_blocks;
    assign last_blk = (idx == n_q - 4'd1);

    // Counter block is derived from latched state, so it holds through the whole core transaction.
    assign aes_in   = iv_q + BLK_W'(idx);

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        aes_start  = (state == S_ISSUE);
        case (state)
            S_IDLE:  if (start) state_next = (n_req == 4'd0) ? S_DONE : S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (aes_done) state_next = last_blk ? S_DONE : S_ISSUE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            pt_q    <= '0;
            iv_q    <= '0;
            n_q     <= '0;
            idx     <= '0;
            text    <= '0;
            aes_key <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pt_q    <= plaintext_in;
                        aes_key <= key;
                        iv_q    <= iv;
                        n_q     <= n_req;
                        idx     <= '0;
                        text    <= '0;
                    end
                end
                S_WAIT: begin
                    if (aes_done) begin
                        for (int i = 0; i < NBLK; i++) begin
                            if (idx == 4'(i)) begin
                                text[NBLK*BLK_W-1-BLK_W*i -: BLK_W] <=
                                    aes_out ^ pt_q[NBLK*BLK_W-1-BLK_W*i -: BLK_W];
                            end
                        end
                        if (!last_blk) idx <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_block_scheduler.sv
// Bench for ctr_block_scheduler: stub AES core (aes_in ^ key[127:0], 3-cycle latency)
// and a block-level CTR reference model.
module tb_ctr_block_scheduler;

    localparam int NBLK  = 8;
    localparam int BLK_W = 128;
    localparam int KEY_W = 256;
    localparam int MSG_W = NBLK * BLK_W;
    localparam int LAT   = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [3:0]         num_blocks = '0;
    logic [MSG_W-1:0]   plaintext_in = '0;
    logic [KEY_W-1:0]   key = '0;
    logic [BLK_W-1:0]   iv = '0;
    logic               busy;
    logic               done;
    logic [MSG_W-1:0]   text;
    logic               aes_start;
    logic [KEY_W-1:0]   aes_key;
    logic [BLK_W-1:0]   aes_in;
    logic               aes_done;
    logic [BLK_W-1:0]   aes_out;

    logic [BLK_W-1:0]   pt_blk [NBLK];
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    ctr_block_scheduler #(.NBLK(NBLK), .BLK_W(BLK_W), .KEY_W(KEY_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_blocks   (num_blocks),
        .plaintext_in (plaintext_in),
        .key          (key),
        .iv           (iv),
        .busy         (busy),
        .done         (done),
        .text         (text),
        .aes_start    (aes_start),
        .aes_key      (aes_key),
        .aes_in       (aes_in),
        .aes_done     (aes_done),
        .aes_out      (aes_out)
    );

    // Stub core is deliberately not reset, so an in-flight request produces a stray aes_done.
    logic [LAT-1:0]   stub_pipe = '0;
    logic [BLK_W-1:0] stub_in   = '0;
    always @(posedge clk) begin
        stub_pipe <= {stub_pipe[LAT-2:0], aes_start};
        if (aes_start) stub_in <= aes_in;
    end
    assign aes_done = stub_pipe[LAT-1];
    assign aes_out  = stub_in ^ aes_key[BLK_W-1:0];

    task automatic check_output(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] model_block(input int i, input int n, input logic [KEY_W-1:0] k,
                                                     input logic [BLK_W-1:0] v);
        if (i >= n) return '0;
        return pt_blk[i] ^ (v + BLK_W'(i)) ^ k[BLK_W-1:0];
    endfunction

    function automatic logic [BLK_W-1:0] text_block(input int i);
        logic [MSG_W-1:0] t;
        t = text;
        return t[MSG_W-1-BLK_W*i -: BLK_W];
    endfunction

    task automatic randomize_pt();
        for (int i = 0; i < NBLK; i++) pt_blk[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic pack_pt();
        for (int i = 0; i < NBLK; i++) plaintext_in[MSG_W-1-BLK_W*i -: BLK_W] = pt_blk[i];
    endtask

    // One full message: checks every counter block issued, done timing, busy length and the final text.
    task automatic apply_stimulus(input string name, input logic [3:0] nb, input logic [KEY_W-1:0] k,
                                  input logic [BLK_W-1:0] v, input bit glitch);
        int n;
        int done_at;
        int busy_cnt;
        int starts;
        n        = (int'(nb) > NBLK) ? NBLK : int'(nb);
        done_at  = -1;
        busy_cnt = 0;
        starts   = 0;
        @(negedge clk);
        pack_pt();
        key        = k;
        iv         = v;
        num_blocks = nb;
        start      = 1'b1;
        for (int cyc = 1; cyc <= 200 && done_at < 0; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (glitch && cyc == 6) begin
                iv    = ~v;
                start = 1'b1;
            end
            if (busy) busy_cnt++;
            if (aes_start) begin
                check_output($sformatf("%s aes_in[%0d]", name, starts), aes_in, v + BLK_W'(starts));
                check_output($sformatf("%s aes_key[%0d]", name, starts), aes_key[BLK_W-1:0], k[BLK_W-1:0]);
                starts++;
            end
            if (done) done_at = cyc;
        end
        start = 1'b0;
        check_output({name, " done_cycle"}, BLK_W'(done_at), BLK_W'(n * (LAT + 1) + 1));
        check_output({name, " busy_cycles"}, BLK_W'(busy_cnt), BLK_W'(n * (LAT + 1) + 1));
        check_output({name, " aes_starts"}, BLK_W'(starts), BLK_W'(n));
        @(posedge clk);
        #1;
        check_output({name, " done_fall"}, BLK_W'(done), '0);
        check_output({name, " busy_fall"}, BLK_W'(busy), '0);
        for (int i = 0; i < NBLK; i++)
            check_output($sformatf("%s text[%0d]", name, i), text_block(i), model_block(i, n, k, v));
    endtask

    initial begin
        int               starts;
        int               stray;
        logic [KEY_W-1:0] k;
        logic [BLK_W-1:0] v;

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1;
        check_output("reset busy", BLK_W'(busy), '0);
        check_output("reset done", BLK_W'(done), '0);
        check_output("reset aes_start", BLK_W'(aes_start), '0);
        check_output("reset aes_in", aes_in, '0);
        check_output("reset aes_key", aes_key[BLK_W-1:0], '0);
        check_output("reset text0", text_block(0), '0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] directed messages");
        for (int i = 0; i < NBLK; i++) pt_blk[i] = '0;
        apply_stimulus("t1_counting", 4'd8, '0, '0, 1'b0);
        apply_stimulus("t2_wrap", 4'd2, '0, '1, 1'b0);
        pt_blk[0] = 128'h01;
        apply_stimulus("t3_single", 4'd1, {128'h0, 128'hff}, 128'h10, 1'b0);
        check_output("t3 block0 literal", text_block(0), 128'hee);
        randomize_pt();
        apply_stimulus("t4_zero", 4'd0, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        randomize_pt();
        apply_stimulus("t5_restart", 4'd8, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom}, 1'b1);

        $display("[TB] reset during block 3");
        randomize_pt();
        @(negedge clk);
        pack_pt();
        key        = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        iv         = {$urandom, $urandom, $urandom, $urandom};
        num_blocks = 4'd8;
        start      = 1'b1;
        starts     = 0;
        for (int cyc = 0; cyc < 100 && starts < 4; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (aes_start) starts++;
        end
        check_output("t6 reached block3", BLK_W'(starts), BLK_W'(4));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("t6 busy", BLK_W'(busy), '0);
        check_output("t6 done", BLK_W'(done), '0);
        check_output("t6 aes_start", BLK_W'(aes_start), '0);
        for (int i = 0; i < NBLK; i++) check_output($sformatf("t6 text[%0d]", i), text_block(i), '0);
        rst   = 1'b1;
        stray = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk);
            #1;
            if (aes_start || done || busy) stray++;
        end
        check_output("t6 stray activity", BLK_W'(stray), '0);
        check_output("t6 text0 after stray", text_block(0), '0);
        randomize_pt();
        apply_stimulus("t6_clean", 4'd5, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom}, 1'b0);

        $display("[TB] random messages");
        for (int r = 0; r < 6; r++) begin
            randomize_pt();
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            v = (r % 2 == 0) ? {$urandom, $urandom, $urandom, $urandom} : ('1 - BLK_W'($urandom_range(0, 4)));
            apply_stimulus($sformatf("rand%0d", r), 4'($urandom_range(0, 15)), k, v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
